dcache_mem_ctrl: RTL and testbench
==================================

Name: dcache_mem_ctrl

Overview:
- Responder side of the data-cache miss/write-through interface.
- Accepts byte, half and word requests from data_cache and from the instruction fetch path.
- Serializes each request into byte transactions on the single byte-wide RAM/IO port.
- Returns assembled read data, or a write-done pulse, to the requester.
- Sits between the caches and the top-level RAM/UART bus. Data requests win arbitration; a transaction in progress is never preempted.

Parameters:
- ADDR_W, 32, width of all address buses and of mem_a.
- IO_ADDR, 32'h30000, UART write address; byte writes here stall while io_buffer_full=1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- data_needed_i  in  1  data cache request valid (level, held until served).
- addr_i  in  ADDR_W  data request base address.
- wr_i  in  1  1=write, 0=read.
- memcnf_i  in  2  size: 01 byte, 10 half, 11 word, 00 no request.
- data_write_i  in  32  write data, little-endian, low bytes used.
- addr_needed_o  out  1  one-cycle pulse: data write fully committed.
- data_available_o  out  1  one-cycle pulse: data read complete, data_o valid.
- data_o  out  32  read data, zero-extended.
- inst_needed_i  in  1  fetch request valid.
- inst_addr_i  in  ADDR_W  fetch address; fetches are always 4 bytes.
- inst_available_o  out  1  one-cycle pulse: inst_o valid.
- inst_o  out  32  fetched word.
- mem_din  in  8  RAM read byte; 1-cycle latency after mem_a.
- io_buffer_full  in  1  UART buffer full.
- mem_a  out  ADDR_W  RAM byte address.
- mem_dout  out  8  RAM write byte.
- mem_wr  out  1  1=write this cycle.

Behaviour:
- Reset:
  - All outputs are 0: data_o, inst_o, addr_needed_o, data_available_o, inst_available_o, mem_a, mem_dout, mem_wr.
  - State goes to IDLE; cnt, assembly register and latched request are cleared.
  - Reset asserted mid-transaction aborts the transaction. No pulse is generated.
- Size: n = 1/2/4 for memcnf 01/10/11. A data request with memcnf=00 is ignored.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - If data_needed_i and memcnf_i!=00: latch addr, wr, n and data, owner=DATA, cnt=0. Go to WR if wr_i, else RD.
  - Else if inst_needed_i: latch inst_addr_i, n=4, owner=INST, go to RD.
  - Else stay in IDLE.
- RD:
  - While cnt<n: mem_a=base+cnt, and cnt increments each cycle.
  - The byte sampled at edge k+2 after accept is byte k. It is placed in bits [8k+7:8k].
  - At the edge sampling byte n-1 (edge n+1): load data_o or inst_o per owner, pulse the matching available output, go to DONE.
  - Word read: accept at edge 0, mem_a=base..base+3 during cycles 1-4, available high during the cycle after edge 5.
- WR:
  - Each cycle: mem_wr=1, mem_a=base+cnt, mem_dout=data[8cnt+7:8cnt], cnt++.
  - Exception: when base==IO_ADDR and io_buffer_full=1, hold with mem_wr=0 and cnt unchanged.
  - At the edge after the last byte is written: addr_needed_o=1, go to DONE.
- DONE:
  - Lasts one cycle. Response pulse is high.
  - Requests are ignored so the same still-asserted request is not re-served.
  - Next state is IDLE; pulses return to 0.
- Outside RD/WR: mem_wr=0 and mem_a=0.
- Address arithmetic is mod 2^ADDR_W (wrap). There is no alignment check; a misaligned half is done bytewise.
- Requests withdrawn mid-transaction are completed anyway; the requester discards the result.
- Simultaneous data and inst requests in IDLE: data is served first. inst is served after DONE if still asserted.

Test Plan:
- RAM[0x100..0x103]=11,22,33,44; word read at 0x100 -> mem_a 0x100..0x103 on consecutive cycles; data_available_o for exactly 1 cycle, 5 edges after accept; data_o=32'h44332211.
- Byte read at 0x101 (RAM=0x22) -> data_o=32'h00000022; half read at 0x102 -> 32'h00004433.
- Word write 32'hDEADBEEF to 0x200 -> mem_wr on 4 cycles, bytes EF,BE,AD,DE at 0x200..0x203; addr_needed_o pulses once; a following read returns the same word.
- Byte write 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those 3 cycles; then one write of 0x41; then addr_needed_o.
- data and inst requests asserted together -> data completes first; inst_available_o follows with no bytes overlapping on mem_a.
- rst driven low mid word read -> outputs 0 asynchronously, no available pulse; after release, a new read completes normally.

Source files
------------

// File: rtl/dcache_mem_ctrl.sv
// Byte-serialising responder between the data/instruction caches and the byte-wide RAM/IO port.
// Data requests win arbitration; a started transaction always runs to its response pulse.
module dcache_mem_ctrl #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_ADDR = 'h30000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_needed_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              wr_i,
   input  logic [1:0]        memcnf_i,
   input  logic [31:0]       data_write_i,
   output logic              addr_needed_o,
   output logic              data_available_o,
   output logic [31:0]       data_o,
   input  logic              inst_needed_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic              inst_available_o,
   output logic [31:0]       inst_o,
   input  logic [7:0]        mem_din,
   input  logic              io_buffer_full,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   output logic [1:0]        dbg_state
);

   // Request/response protocol: a request is a level held until served and is taken only in
   // IDLE; completion is a single-cycle pulse (addr_needed_o, data_available_o or
   // inst_available_o), after which DONE ignores the still-held request for one cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       asm_q;
   logic [2:0]        cnt;
   logic [2:0]        len;
   logic              owner_inst;
   logic              io_stall;
   logic [31:0]       rd_word;
   logic [ADDR_W-1:0] cur_addr;

   function automatic logic [2:0] size_len(input logic [1:0] cnf);
      case (cnf)
         2'b01:   return 3'd1;
         2'b10:   return 3'd2;
         2'b11:   return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   assign cur_addr  = base + {{(ADDR_W-3){1'b0}}, cnt};
   assign io_stall  = (base == IO_ADDR) && io_buffer_full;
   assign dbg_state = state;

   // Byte k of a read arrives one cycle after its address, i.e. while cnt == k+1.
   always_comb begin
      mem_wr   = 1'b0;
      mem_a    = '0;
      mem_dout = '0;
      rd_word  = asm_q;
      case (state)
         RD: begin
            if (cnt < len) mem_a = cur_addr;
            for (int k = 0; k < 4; k++) begin
               if (cnt == 3'(k + 1)) rd_word[8*k +: 8] = mem_din;
            end
         end
         WR: begin
            mem_a  = cur_addr;
            mem_wr = !io_stall;
            for (int k = 0; k < 4; k++) begin
               if (cnt == 3'(k)) mem_dout = wdata[8*k +: 8];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         base             <= '0;
         wdata            <= '0;
         asm_q            <= '0;
         cnt              <= '0;
         len              <= '0;
         owner_inst       <= 1'b0;
         data_o           <= '0;
         inst_o           <= '0;
         addr_needed_o    <= 1'b0;
         data_available_o <= 1'b0;
         inst_available_o <= 1'b0;
      end else begin
         addr_needed_o    <= 1'b0;
         data_available_o <= 1'b0;
         inst_available_o <= 1'b0;
         case (state)
            IDLE: begin
               if (data_needed_i && memcnf_i != 2'b00) begin
                  base       <= addr_i;
                  len        <= size_len(memcnf_i);
                  wdata      <= data_write_i;
                  owner_inst <= 1'b0;
                  cnt        <= '0;
                  asm_q      <= '0;
                  state      <= wr_i ? WR : RD;
               end else if (inst_needed_i) begin
                  base       <= inst_addr_i;
                  len        <= 3'd4;
                  owner_inst <= 1'b1;
                  cnt        <= '0;
                  asm_q      <= '0;
                  state      <= RD;
               end
            end
            RD: begin
               asm_q <= rd_word;
               if (cnt == len) begin
                  if (owner_inst) begin
                     inst_o           <= rd_word;
                     inst_available_o <= 1'b1;
                  end else begin
                     data_o           <= rd_word;
                     data_available_o <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            WR: begin
               if (!io_stall) begin
                  if (cnt == len - 3'd1) begin
                     addr_needed_o <= 1'b1;
                     state         <= DONE;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: byte RAM/UART model, transaction driver and a byte-level
// reference memory that predicts read data, write traffic, address sequences and latency.
module tb_dcache_mem_ctrl;

   localparam logic [31:0] IO_ADDR = 32'h30000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        data_needed_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic        wr_i = 1'b0;
   logic [1:0]  memcnf_i = '0;
   logic [31:0] data_write_i = '0;
   logic        addr_needed_o, data_available_o, inst_available_o;
   logic [31:0] data_o, inst_o;
   logic        inst_needed_i = 1'b0;
   logic [31:0] inst_addr_i = '0;
   logic [7:0]  mem_din;
   logic        io_buffer_full = 1'b0;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [1:0]  dbg_state;

   dcache_mem_ctrl #(.ADDR_W(32), .IO_ADDR(IO_ADDR)) dut (
      .clk(clk), .rst(rst),
      .data_needed_i(data_needed_i), .addr_i(addr_i), .wr_i(wr_i), .memcnf_i(memcnf_i),
      .data_write_i(data_write_i), .addr_needed_o(addr_needed_o),
      .data_available_o(data_available_o), .data_o(data_o),
      .inst_needed_i(inst_needed_i), .inst_addr_i(inst_addr_i),
      .inst_available_o(inst_available_o), .inst_o(inst_o),
      .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- RAM / UART model ----------------
   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         default: return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   logic [7:0] ram   [0:65535];
   bit         wmask [0:65535];
   logic [7:0] uart_q[$];

   always @(posedge clk) begin
      mem_din <= wmask[mem_a[15:0]] ? ram[mem_a[15:0]] : init_byte({16'h0, mem_a[15:0]});
      if (mem_wr && mem_a != IO_ADDR) begin
         ram[mem_a[15:0]]   <= mem_dout;
         wmask[mem_a[15:0]] <= 1'b1;
      end
      if (mem_wr && mem_a == IO_ADDR) uart_q.push_back(mem_dout);
   end

   // ---------------- reference model ----------------
   logic [7:0] model_mem [0:65535];

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] r;
      logic [31:0] x;
      r = '0;
      for (int i = 0; i < n; i++) begin
         x = a + 32'(i);
         r[8*i +: 8] = model_mem[x[15:0]];
      end
      return r;
   endfunction

   task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] wd);
      logic [31:0] x;
      for (int i = 0; i < n; i++) begin
         x = a + 32'(i);
         if (x != IO_ADDR) model_mem[x[15:0]] = wd[8*i +: 8];
      end
   endtask

   // Scoreboard: expected per-cycle mem_a for reads and expected {addr, byte} write records.
   logic [31:0] exp_q[$];
   logic [39:0] exp_w_q[$];
   logic [31:0] obs_a_q[$];
   logic [39:0] obs_w_q[$];

   task automatic build_rd_exp(input logic [31:0] a, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(a + 32'(i));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
   endtask

   task automatic build_wr_exp(input logic [31:0] a, input int n, input logic [31:0] wd);
      exp_w_q.delete();
      for (int i = 0; i < n; i++) exp_w_q.push_back({a + 32'(i), wd[8*i +: 8]});
   endtask

   function automatic int cnf_len(input logic [1:0] cnf);
      return (cnf == 2'b01) ? 1 : (cnf == 2'b10) ? 2 : 4;
   endfunction

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- driver ----------------
   int          stall_cycles = 0;
   bit          junk_data = 1'b0;
   int          res_lat, res_first_wr;
   logic [31:0] res_data;
   bit          res_wrong_pulse, res_post_busy;

   task automatic run_txn(input bit is_inst, input bit wr, input logic [1:0] cnf,
                          input logic [31:0] addr, input logic [31:0] wd);
      bit       hit;
      logic [2:0] exp_p;
      obs_a_q.delete();
      obs_w_q.delete();
      res_lat = 0; res_first_wr = 0; res_data = '0;
      res_wrong_pulse = 1'b0; res_post_busy = 1'b0;
      exp_p = is_inst ? 3'b001 : (wr ? 3'b100 : 3'b010);
      @(posedge clk); #1;
      if (is_inst) begin
         inst_needed_i = 1'b1; inst_addr_i = addr;
         data_needed_i = junk_data; memcnf_i = 2'b00; wr_i = 1'b0;
      end else begin
         data_needed_i = 1'b1; addr_i = addr; wr_i = wr; memcnf_i = cnf; data_write_i = wd;
      end
      io_buffer_full = (stall_cycles > 0);
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         #1 io_buffer_full = (c <= stall_cycles);
         @(negedge clk);
         obs_a_q.push_back(mem_a);
         if (mem_wr) begin
            obs_w_q.push_back({mem_a, mem_dout});
            if (res_first_wr == 0) res_first_wr = c;
         end
         hit = is_inst ? inst_available_o : (wr ? addr_needed_o : data_available_o);
         if ({addr_needed_o, data_available_o, inst_available_o} != (hit ? exp_p : 3'b000))
            res_wrong_pulse = 1'b1;
         if (hit) begin
            res_lat  = c;
            res_data = is_inst ? inst_o : data_o;
            break;
         end
         @(posedge clk);
      end
      // request stays asserted across the DONE edge, then is dropped
      @(posedge clk); #1;
      data_needed_i = 1'b0; inst_needed_i = 1'b0; memcnf_i = 2'b00; wr_i = 1'b0;
      io_buffer_full = 1'b0;
      @(negedge clk);
      res_post_busy = mem_wr || (mem_a != 0) || addr_needed_o || data_available_o || inst_available_o;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({data_o, inst_o, addr_needed_o, data_available_o, inst_available_o, mem_a, mem_dout, mem_wr} !== '0)
         $display("FAIL reset_outputs: data_o=%h inst_o=%h mem_a=%h mem_dout=%h mem_wr=%b pulses=%b%b%b, expected all 0",
                  data_o, inst_o, mem_a, mem_dout, mem_wr, addr_needed_o, data_available_o, inst_available_o);
      else n_pass++;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({addr_needed_o, data_available_o, inst_available_o, mem_a, mem_wr} !== '0)
         $display("FAIL idle_outputs: mem_a=%h mem_wr=%b pulses=%b%b%b, expected all 0",
                  mem_a, mem_wr, addr_needed_o, data_available_o, inst_available_o);
      else n_pass++;
   endtask

   task automatic check_read(input string name, input logic [31:0] a, input int n, input logic [31:0] want);
      bit ok;
      build_rd_exp(a, n);
      n_checks++;
      if (res_data !== want) $display("FAIL %s_data: got %h, expected %h", name, res_data, want);
      else n_pass++;
      n_checks++;
      if (res_lat != n + 2) $display("FAIL %s_latency: got %0d, expected %0d", name, res_lat, n + 2);
      else n_pass++;
      ok = (obs_a_q.size() == exp_q.size());
      foreach (exp_q[i]) if (i < obs_a_q.size() && obs_a_q[i] !== exp_q[i]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL %s_mem_a_seq: first addr %h, %0d cycles, expected %h over %0d cycles",
                        name, obs_a_q.size() ? obs_a_q[0] : 32'hx, obs_a_q.size(), exp_q[0], exp_q.size());
      else n_pass++;
      n_checks++;
      if (res_wrong_pulse || res_post_busy || obs_w_q.size() != 0)
         $display("FAIL %s_side_effects: wrong_pulse=%b post_busy=%b writes=%0d, expected 0/0/0",
                  name, res_wrong_pulse, res_post_busy, obs_w_q.size());
      else n_pass++;
   endtask

   task automatic check_write(input string name, input logic [31:0] a, input int n,
                              input logic [31:0] wd, input int stall);
      bit ok;
      build_wr_exp(a, n, wd);
      ok = (obs_w_q.size() == exp_w_q.size());
      foreach (exp_w_q[i]) if (i < obs_w_q.size() && obs_w_q[i] !== exp_w_q[i]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL %s_bytes: first %h, %0d writes, expected %h over %0d writes",
                        name, obs_w_q.size() ? obs_w_q[0] : 40'hx, obs_w_q.size(), exp_w_q[0], exp_w_q.size());
      else n_pass++;
      n_checks++;
      if (res_lat != n + 1 + stall) $display("FAIL %s_latency: got %0d, expected %0d", name, res_lat, n + 1 + stall);
      else n_pass++;
      n_checks++;
      if (res_wrong_pulse || res_post_busy)
         $display("FAIL %s_side_effects: wrong_pulse=%b post_busy=%b, expected 0/0", name, res_wrong_pulse, res_post_busy);
      else n_pass++;
   endtask

   task automatic test_word_read();
      run_txn(1'b0, 1'b0, 2'b11, 32'h100, '0);
      check_read("word_read", 32'h100, 4, model_read(32'h100, 4));
      n_checks++;
      if (res_data !== 32'h44332211) $display("FAIL word_read_const: got %h, expected 44332211", res_data);
      else n_pass++;
   endtask

   task automatic test_byte_half_read();
      run_txn(1'b0, 1'b0, 2'b01, 32'h101, '0);
      check_read("byte_read", 32'h101, 1, 32'h00000022);
      run_txn(1'b0, 1'b0, 2'b10, 32'h102, '0);
      check_read("half_read", 32'h102, 2, 32'h00004433);
      run_txn(1'b0, 1'b0, 2'b10, 32'h103, '0);
      check_read("misaligned_half", 32'h103, 2, model_read(32'h103, 2));
   endtask

   task automatic test_word_write();
      model_write(32'h200, 4, 32'hDEADBEEF);
      run_txn(1'b0, 1'b1, 2'b11, 32'h200, 32'hDEADBEEF);
      check_write("word_write", 32'h200, 4, 32'hDEADBEEF, 0);
      run_txn(1'b0, 1'b0, 2'b11, 32'h200, '0);
      check_read("readback", 32'h200, 4, 32'hDEADBEEF);
   endtask

   task automatic test_io_stall();
      int uart_before;
      uart_before = uart_q.size();
      stall_cycles = 3;
      run_txn(1'b0, 1'b1, 2'b01, IO_ADDR, 32'h00000041);
      stall_cycles = 0;
      check_write("io_write", IO_ADDR, 1, 32'h41, 3);
      n_checks++;
      if (res_first_wr != 4) $display("FAIL io_stall_first_write: cycle %0d, expected 4", res_first_wr);
      else n_pass++;
      n_checks++;
      if (uart_q.size() != uart_before + 1 || uart_q[uart_q.size()-1] !== 8'h41)
         $display("FAIL io_uart_byte: count %0d, expected %0d ending in 41", uart_q.size(), uart_before + 1);
      else n_pass++;
   endtask

   task automatic test_arbitration();
      int          data_c, inst_c;
      logic [31:0] dw, iw;
      bit          ok;
      data_c = 0; inst_c = 0; dw = '0; iw = '0;
      obs_a_q.delete();
      @(posedge clk); #1;
      data_needed_i = 1'b1; wr_i = 1'b0; memcnf_i = 2'b11; addr_i = 32'h300;
      inst_needed_i = 1'b1; inst_addr_i = 32'h400;
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         obs_a_q.push_back(mem_a);
         if (data_available_o && data_c == 0) begin data_c = c; dw = data_o; end
         if (inst_available_o) begin inst_c = c; iw = inst_o; break; end
         @(posedge clk); #1;
         if (data_c != 0) data_needed_i = 1'b0;
      end
      @(posedge clk); #1;
      data_needed_i = 1'b0; inst_needed_i = 1'b0; memcnf_i = 2'b00;
      // data word at cycles 1-4, DONE at 6, IDLE at 7, inst accepted at edge 7, inst bytes 8-11
      exp_q.delete();
      for (int c = 1; c <= 13; c++)
         exp_q.push_back((c <= 4) ? 32'h300 + 32'(c - 1) : (c >= 8 && c <= 11) ? 32'h400 + 32'(c - 8) : 32'h0);
      n_checks++;
      if (data_c != 6 || inst_c != 13)
         $display("FAIL arb_order: data pulse cycle %0d inst pulse cycle %0d, expected 6 and 13", data_c, inst_c);
      else n_pass++;
      n_checks++;
      if (dw !== model_read(32'h300, 4)) $display("FAIL arb_data: got %h, expected %h", dw, model_read(32'h300, 4));
      else n_pass++;
      n_checks++;
      if (iw !== model_read(32'h400, 4)) $display("FAIL arb_inst: got %h, expected %h", iw, model_read(32'h400, 4));
      else n_pass++;
      ok = (obs_a_q.size() == exp_q.size());
      foreach (exp_q[i]) if (i < obs_a_q.size() && obs_a_q[i] !== exp_q[i]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL arb_mem_a_seq: %0d cycles observed, expected %0d with no overlap", obs_a_q.size(), exp_q.size());
      else n_pass++;
      // data request with size 00 must be ignored in favour of the fetch
      junk_data = 1'b1;
      run_txn(1'b1, 1'b0, 2'b00, 32'h100, '0);
      junk_data = 1'b0;
      check_read("inst_over_null_data", 32'h100, 4, model_read(32'h100, 4));
   endtask

   task automatic test_random();
      int          kind, n, stall;
      logic [1:0]  cnf;
      logic [31:0] a, wd;
      for (int t = 0; t < 40; t++) begin
         kind  = $urandom_range(0, 2);
         cnf   = 2'($urandom_range(1, 3));
         a     = 32'($urandom_range(0, 16'h3FFF));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
         wd    = $urandom;
         stall = $urandom_range(0, 2);
         stall_cycles = stall;
         if (kind == 0) begin
            run_txn(1'b1, 1'b0, 2'b11, a, '0);
            check_read("rand_inst", a, 4, model_read(a, 4));
         end else if (kind == 1) begin
            n = cnf_len(cnf);
            run_txn(1'b0, 1'b0, cnf, a, '0);
            check_read("rand_read", a, n, model_read(a, n));
         end else begin
            n = cnf_len(cnf);
            model_write(a, n, wd);
            run_txn(1'b0, 1'b1, cnf, a, wd);
            check_write("rand_write", a, n, wd, 0);
         end
      end
      stall_cycles = 0;
   endtask

   task automatic test_reset_mid_read();
      bit pulse_seen;
      pulse_seen = 1'b0;
      @(posedge clk); #1;
      data_needed_i = 1'b1; wr_i = 1'b0; memcnf_i = 2'b11; addr_i = 32'h100;
      @(posedge clk);
      @(posedge clk); #1;
      data_needed_i = 1'b0; memcnf_i = 2'b00;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({data_o, inst_o, addr_needed_o, data_available_o, inst_available_o, mem_a, mem_dout, mem_wr} !== '0)
         $display("FAIL async_reset_outputs: data_o=%h inst_o=%h mem_a=%h mem_wr=%b, expected all 0",
                  data_o, inst_o, mem_a, mem_wr);
      else n_pass++;
      repeat (3) begin
         @(negedge clk);
         if (addr_needed_o || data_available_o || inst_available_o) pulse_seen = 1'b1;
      end
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (addr_needed_o || data_available_o || inst_available_o || mem_a != 0) pulse_seen = 1'b1;
      end
      n_checks++;
      if (pulse_seen) $display("FAIL aborted_read_pulse: got activity 1, expected 0");
      else n_pass++;
      run_txn(1'b0, 1'b0, 2'b11, 32'h200, '0);
      check_read("read_after_reset", 32'h200, 4, model_read(32'h200, 4));
   endtask

   // ---------------- main + final report ----------------
   initial begin
      for (int i = 0; i < 65536; i++) model_mem[i] = init_byte(32'(i));
      test_reset();
      test_word_read();
      test_byte_half_read();
      test_word_write();
      test_io_stall();
      test_arbitration();
      test_random();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
